// File: rtl/mem_responder_if.sv
// Request/response bus between a CPU-side requester and the word RAM responder.
// One outstanding request; valid/ready on both the request and response channels.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_addr, req_we, req_wstrb, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wstrb, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/mem_responder.sv
// Word RAM responder with a fixed, programmable accept-to-response latency.
// Image preload (INIT_FILE) is left to the simulation environment; the RAM has no reset.
module mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          LATENCY     = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_responder_if.slave bus
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
    $error("mem_responder: LATENCY %0d outside 1..15", LATENCY);
  end
  if (INIT_FILE != "") begin : g_init_note
    $info("mem_responder: INIT_FILE %s must be loaded by the environment", INIT_FILE);
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } rsp_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  rsp_t        rsp_q, rsp_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]     off, word_off;
  logic            aligned, in_range, dec_err;
  logic [IDXW-1:0] idx;
  logic            accept;

  // Decode is combinational on the live request; everything needed later is
  // captured on the accept edge so the requester may change its inputs after.
  assign off      = bus.req_addr - BASE_ADDR;
  assign word_off = off >> 2;
  assign aligned  = (bus.req_addr[1:0] == 2'b00);
  assign in_range = (bus.req_addr >= BASE_ADDR) && (word_off < 32'(DEPTH_WORDS));
  assign dec_err  = !aligned || !in_range;
  assign idx      = word_off[IDXW-1:0];
  assign accept   = (state_q == IDLE) && bus.req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_d.error = dec_err;
          rsp_d.rdata = (bus.req_we || dec_err) ? 32'h0 : mem_q[idx];
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rsp_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        rsp_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  // Writes commit on the accept edge, so a later reset cannot undo them.
  always_ff @(posedge clk) begin
    if (reset_n && accept && bus.req_we && !dec_err) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_wstrb[b]) mem_q[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_error = rsp_q.error;

endmodule

// File: tb/tb_mem_responder.sv
// Bench: three responders at LATENCY 1, 3, 15 run the same directed and random
// traffic; a per-instance transaction-level model checks every output each cycle.
module tb_mem_responder;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          N     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_n_a     [N];
  logic        req_valid_a [N];
  logic [31:0] req_addr_a  [N];
  logic        req_we_a    [N];
  logic [3:0]  req_wstrb_a [N];
  logic [31:0] req_wdata_a [N];
  logic        rsp_ready_a [N];
  wire         req_ready_w [N];
  wire         rsp_valid_w [N];
  wire  [31:0] rsp_rdata_w [N];
  wire         rsp_error_w [N];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 15;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lat=%0d actual=%h required=%h", nm, lat_of(k), act, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 15;

    mem_responder_if bus ();
    assign bus.req_valid   = req_valid_a[g];
    assign bus.req_addr    = req_addr_a[g];
    assign bus.req_we      = req_we_a[g];
    assign bus.req_wstrb   = req_wstrb_a[g];
    assign bus.req_wdata   = req_wdata_a[g];
    assign bus.rsp_ready   = rsp_ready_a[g];
    assign req_ready_w[g]  = bus.req_ready;
    assign rsp_valid_w[g]  = bus.rsp_valid;
    assign rsp_rdata_w[g]  = bus.rsp_rdata;
    assign rsp_error_w[g]  = bus.rsp_error;

    mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(L), .INIT_FILE("")) dut (
      .clk     (clk),
      .reset_n (rst_n_a[g]),
      .bus     (bus)
    );

    // Model: one pending transaction stamped with its accept cycle.
    logic [31:0] mem_m [DEPTH];
    bit          pend = 1'b0;
    int          acc_t = 0;
    int          t = 0;
    logic [31:0] m_rd = '0;
    bit          m_er = 1'b0;

    always @(negedge clk) begin
      bit          ev;
      logic [31:0] a;
      int          i;
      if (!rst_n_a[g]) begin
        pend = 1'b0;
      end else begin
        ev = pend && (t - acc_t >= L);
        chk("req_ready", g, 32'(req_ready_w[g]), 32'(!pend));
        chk("rsp_valid", g, 32'(rsp_valid_w[g]), 32'(ev));
        if (ev || !pend) begin
          chk("rsp_rdata", g, rsp_rdata_w[g], ev ? m_rd : 32'h0);
          chk("rsp_error", g, 32'(rsp_error_w[g]), ev ? 32'(m_er) : 32'h0);
        end
        if (ev && rsp_ready_a[g]) begin
          pend = 1'b0;
        end else if (!pend && req_valid_a[g]) begin
          a    = req_addr_a[g];
          m_er = (a % 4 != 0) || (a < BASE) || ((a - BASE) / 4 >= DEPTH);
          m_rd = 32'h0;
          if (!m_er) begin
            i = int'((a - BASE) / 4);
            if (req_we_a[g]) begin
              for (int b = 0; b < 4; b++)
                if (req_wstrb_a[g][b]) mem_m[i][8*b +: 8] = req_wdata_a[g][8*b +: 8];
            end else begin
              m_rd = mem_m[i];
            end
          end
          pend  = 1'b1;
          acc_t = t;
        end
      end
      t++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic xact(input int k, input bit we, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int hold,
                      output logic [31:0] rd, output bit er, output int lat);
    int n;
    req_valid_a[k] = 1'b1; req_we_a[k] = we; req_addr_a[k] = a;
    req_wstrb_a[k] = s;    req_wdata_a[k] = d; rsp_ready_a[k] = 1'b0;
    n = 0;
    while (!req_ready_w[k] && n < 100) begin cyc(); n++; end
    if (n >= 100) chk("accept_timeout", k, 32'(n), 32'h0);
    cyc();
    req_valid_a[k] = 1'b0;
    req_addr_a[k]  = $urandom;
    req_wdata_a[k] = $urandom;
    lat = 1;
    while (!rsp_valid_w[k] && lat < 40) begin cyc(); lat++; end
    if (lat >= 40) chk("rsp_timeout", k, 32'(lat), 32'h0);
    for (int h = 0; h < hold; h++) begin
      // A competing request that must stay unaccepted while the response waits.
      req_valid_a[k] = 1'b1; req_we_a[k] = 1'b0; req_addr_a[k] = 32'h0;
      cyc();
    end
    req_valid_a[k] = 1'b0;
    rsp_ready_a[k] = 1'b1;
    rd = rsp_rdata_w[k];
    er = rsp_error_w[k];
    cyc();
    rsp_ready_a[k] = 1'b0;
  endtask

  task automatic abort_xact(input int k, input bit we, input logic [31:0] a, input logic [31:0] d);
    int n;
    req_valid_a[k] = 1'b1; req_we_a[k] = we; req_addr_a[k] = a;
    req_wstrb_a[k] = 4'hF; req_wdata_a[k] = d; rsp_ready_a[k] = 1'b0;
    n = 0;
    while (!req_ready_w[k] && n < 100) begin cyc(); n++; end
    cyc();
    req_valid_a[k] = 1'b0;
    cyc();
    rst_n_a[k] = 1'b0;
    cyc(); cyc();
    rst_n_a[k] = 1'b1;
    cyc();
    chk("post_rst_ready", k, 32'(req_ready_w[k]), 32'h1);
    chk("post_rst_valid", k, 32'(rsp_valid_w[k]), 32'h0);
  endtask

  task automatic run(input int k);
    logic [31:0] rd, w0;
    bit          er;
    int          lat;
    chk("rst_ready", k, 32'(req_ready_w[k]), 32'h1);
    chk("rst_valid", k, 32'(rsp_valid_w[k]), 32'h0);
    chk("rst_rdata", k, rsp_rdata_w[k], 32'h0);
    chk("rst_error", k, 32'(rsp_error_w[k]), 32'h0);
    for (int i = 0; i < DEPTH; i++) xact(k, 1'b1, BASE + 32'(i * 4), 4'hF, $urandom, 0, rd, er, lat);

    xact(k, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, rd, er, lat);
    chk("wr_ack_rdata", k, rd, 32'h0);
    chk("wr_latency", k, 32'(lat), 32'(lat_of(k)));
    xact(k, 1'b0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat);
    chk("rd_data", k, rd, 32'hDEADBEEF);
    chk("rd_error", k, 32'(er), 32'h0);
    chk("rd_latency", k, 32'(lat), 32'(lat_of(k)));

    xact(k, 1'b1, 32'h20, 4'hF, 32'h11223344, 0, rd, er, lat);
    xact(k, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 0, rd, er, lat);
    xact(k, 1'b0, 32'h20, 4'h0, 32'h0, 0, rd, er, lat);
    chk("strobe_merge", k, rd, 32'h11BB33DD);

    xact(k, 1'b0, 32'h22, 4'h0, 32'h0, 0, rd, er, lat);
    chk("misalign_err", k, 32'(er), 32'h1);
    chk("misalign_rd", k, rd, 32'h0);
    xact(k, 1'b0, 32'(DEPTH * 4), 4'h0, 32'h0, 0, rd, er, lat);
    chk("oob_err", k, 32'(er), 32'h1);
    chk("oob_rd", k, rd, 32'h0);
    xact(k, 1'b0, 32'h0, 4'h0, 32'h0, 0, w0, er, lat);
    xact(k, 1'b1, 32'(DEPTH * 4), 4'hF, ~w0, 0, rd, er, lat);
    chk("oob_wr_err", k, 32'(er), 32'h1);
    xact(k, 1'b0, 32'h0, 4'h0, 32'h0, 0, rd, er, lat);
    chk("oob_wr_word0", k, rd, w0);
    xact(k, 1'b1, 32'h10, 4'h0, 32'h12345678, 0, rd, er, lat);
    chk("nostrb_err", k, 32'(er), 32'h0);
    xact(k, 1'b0, 32'h10, 4'h0, 32'h0, 5, rd, er, lat);
    chk("backpress_rd", k, rd, 32'hDEADBEEF);

    abort_xact(k, 1'b1, 32'h30, 32'hCAFEF00D);
    abort_xact(k, 1'b0, 32'h10, 32'h0);
    xact(k, 1'b0, 32'h30, 4'h0, 32'h0, 0, rd, er, lat);
    chk("rst_write_kept", k, rd, 32'hCAFEF00D);

    for (int c = 0; c < 400; c++) begin
      int r;
      r = int'($urandom % 8);
      req_valid_a[k] = 1'($urandom);
      req_we_a[k]    = 1'($urandom);
      req_wstrb_a[k] = 4'($urandom);
      req_wdata_a[k] = $urandom;
      rsp_ready_a[k] = 1'($urandom);
      if (r == 0)      req_addr_a[k] = BASE + 32'(($urandom % DEPTH) * 4 + 1 + ($urandom % 3));
      else if (r == 1) req_addr_a[k] = BASE + 32'(DEPTH * 4) + 32'(($urandom % 16) * 4);
      else             req_addr_a[k] = BASE + 32'(($urandom % DEPTH) * 4);
      cyc();
    end
    req_valid_a[k] = 1'b0;
    rsp_ready_a[k] = 1'b1;
    repeat (20) cyc();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rst_n_a[k] = 1'b0; req_valid_a[k] = 1'b0; req_addr_a[k] = '0; req_we_a[k] = 1'b0;
      req_wstrb_a[k] = '0; req_wdata_a[k] = '0; rsp_ready_a[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < N; k++) rst_n_a[k] = 1'b1;
    cyc();
    fork
      run(0);
      run(1);
      run(2);
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog lat=all actual=running required=done");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
